reg_bank_write_arbiter: RTL and testbench
=========================================

# reg_bank_write_arbiter

Shares one bank of D n-bit clocked registers among R independent writers. Each cycle it picks at most one pending write by round-robin, commits it to the bank, and returns a one-cycle grant pulse to the winner. It also provides one registered read port. It sits between multiple producer blocks and a common register bank, and replaces ad-hoc muxing in front of plain register stages.

## Interface
- n, 8, data width of each register
- R, 4, number of requesters (≥2)
- AW, 2, address width; bank depth D = 2**AW
- clk  input  1  rising-edge clock; only clock
- reset  input  1  synchronous, active-high reset
- req  input  R  req[i]=1: requester i has a pending write
- wr_addr  input  R*AW  requester i address at [i*AW +: AW]
- wr_data  input  R*n  requester i data at [i*n +: n]
- gnt  output  R  one-hot/zero, registered; gnt[i]=1 for exactly one cycle per committed write of requester i
- rd_addr  input  AW  read address
- rd_data  output  n  registered read data

## Operation
- Effective request: ereq[i] = req[i] & ~gnt[i]. A requester is never re-granted in the cycle it sees gnt.
- Round-robin pointer ptr (width ceil(log2 R)), reset 0. Search order: ptr, ptr+1, …, R-1, 0, …, ptr-1. The first set ereq wins.
- On each edge where any ereq is set, for winner w:
  - bank[wr_addr_w] <= wr_data_w
  - gnt <= one-hot(w)
  - ptr <= (w+1) mod R
- On each edge where no ereq is set: gnt <= 0, ptr holds, bank holds.
- Requester protocol: hold req, wr_addr and wr_data stable until gnt[i] is seen. In the gnt cycle, drop req, or keep it high with new addr/data for a further write. That new write is eligible from the following edge.
- Only one write per cycle, so same-address conflicts resolve by grant order. The last grant wins.
- Read: every edge, rd_data <= bank[rd_addr]. A write and a read to the same address on one edge return the old value. The new value appears one cycle later.
- Reset values: bank all 0, gnt 0, ptr 0, rd_data 0.
- Reset mid-operation:
  - Pending requests are dropped with no grant and no bank write on the reset edge.
  - Requesters keep req asserted and are arbitrated from ptr=0 after reset deasserts.

## Timing
- Uncontested write: req sampled at edge k; data in bank and gnt high after edge k; gnt low after edge k+1.
- Write-to-read: a write committed at edge k is visible on rd_data after edge k+1 when rd_addr targets it.
- Throughput: one write per cycle total.
- Back-to-back requester: a single requester holding req continuously gets at most one grant every 2 cycles, because of gnt masking.
- No combinational path from any input to gnt or rd_data.

## Configuration
- REG_ARB_PRIO0_EN defined:
  - Requester 0 wins whenever ereq[0]=1, regardless of ptr.
  - ptr updates only when a requester other than 0 wins.
  - Other requesters use round-robin among themselves.
- REG_ARB_PRIO0_EN undefined: pure round-robin over all R requesters, with requester 0 treated identically to the others.

## Test plan
1. Reset, single write, read-back:
   - Stimulus: hold reset 2 cycles, then read addresses 0..3.
   - Response: rd_data=0 for every address and gnt=0 throughout.
   - Stimulus: req[2] with addr 1, data 0xA5.
   - Response: gnt=4'b0100 for exactly one cycle; rd_addr=1 gives rd_data=0xA5 one cycle after commit.
2. Full contention, macro undefined:
   - Stimulus: req=4'b1111 held from ptr=0, each requester writing addr=i, data=0x10+i.
   - Response: gnt sequence 0001, 0010, 0100, 1000, 0001; bank[i]=0x10+i.
3. Same-address ordering:
   - Stimulus: ptr=0; req[1] and req[3] both to addr 0 with data 0x11 and 0x33.
   - Response: gnt[1] then gnt[3]; final bank[0]=0x33.
4. Read-during-write:
   - Stimulus: bank[2]=0x00; rd_addr=2 held while 0x5A is written to addr 2.
   - Response: rd_data=0x00 on the commit edge, 0x5A on the next edge.
5. Reset mid-operation:
   - Stimulus: req=4'b1110 pending; reset pulses for 1 cycle.
   - Response: no write on the reset edge; bank and ptr cleared; first grant after release goes to requester 1.
6. Priority override, REG_ARB_PRIO0_EN defined:
   - Stimulus: req[0] and req[2] held continuously.
   - Response: gnt alternates 0001, 0100, 0001, 0100.

Source files
------------

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a D-entry register bank with one registered read port.
// Define REG_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module reg_bank_write_arbiter #(
   parameter int n  = 8,
   parameter int R  = 4,
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [R-1:0]    req,
   input  logic [R*AW-1:0] wr_addr,
   input  logic [R*n-1:0]  wr_data,
   output logic [R-1:0]    gnt,
   input  logic [AW-1:0]   rd_addr,
   output logic [n-1:0]    rd_data
);

   localparam int D  = 2**AW;
   localparam int PW = (R > 1) ? $clog2(R) : 1;

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_next_s;
   logic [PW-1:0] win_idx_s;
   logic [PW-1:0] cand_s;
   logic          win_valid_s;
   logic          ptr_upd_s;
   logic [R-1:0]  ereq_s;
   logic [R-1:0]  gnt_r;
   logic [R-1:0]  gnt_next_s;
   logic [AW-1:0] waddr_s;
   logic [n-1:0]  wdata_s;
   logic [n-1:0]  bank_r [D];
   logic [n-1:0]  rd_data_r;

   // Winner selection: first effective request at or after ptr, wrapping around.
   always_comb begin
      ereq_s      = req & ~gnt_r;
      win_valid_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 0; k < R; k++) begin
         cand_s = PW'((int'(ptr_r) + k) % R);
         if (!win_valid_s && ereq_s[cand_s]) begin
            win_valid_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_valid_s = win_valid_s;
         end
      end
`ifdef REG_ARB_PRIO0_EN
      // Requester 0 overrides the rotation and leaves the pointer untouched.
      if (ereq_s[0]) begin
         win_valid_s = 1'b1;
         win_idx_s   = '0;
      end else begin
         win_idx_s   = win_idx_s;
      end
      ptr_upd_s = win_valid_s && (win_idx_s != '0);
`else
      ptr_upd_s = win_valid_s;
`endif
      if (win_idx_s == PW'(R - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = win_idx_s + PW'(1);
      end
      if (win_valid_s) begin
         gnt_next_s = R'(1'b1) << win_idx_s;
      end else begin
         gnt_next_s = '0;
      end
      waddr_s = wr_addr[int'(win_idx_s)*AW +: AW];
      wdata_s = wr_data[int'(win_idx_s)*n +: n];
   end

   // Grant pulse and rotation pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_r <= '0;
         ptr_r <= '0;
      end else begin
         gnt_r <= gnt_next_s;
         if (ptr_upd_s) begin
            ptr_r <= ptr_next_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   // Bank storage and registered read; a same-edge read returns the pre-write value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < D; d++) begin
            bank_r[d] <= '0;
         end
         rd_data_r <= '0;
      end else begin
         if (win_valid_s) begin
            bank_r[waddr_s] <= wdata_s;
         end else begin
            bank_r[waddr_s] <= bank_r[waddr_s];
         end
         rd_data_r <= bank_r[rd_addr];
      end
   end

   assign gnt     = gnt_r;
   assign rd_data = rd_data_r;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_reg_bank_write_arbiter;

   localparam int N  = 8;
   localparam int R  = 4;
   localparam int AW = 2;
   localparam int D  = 4;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [R-1:0]    req;
   logic [R*AW-1:0] wr_addr;
   logic [R*N-1:0]  wr_data;
   logic [R-1:0]    gnt;
   logic [AW-1:0]   rd_addr;
   logic [N-1:0]    rd_data;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   logic [N-1:0] m_bank [D];
   int           m_ptr;
   logic [R-1:0] m_gnt;
   logic [N-1:0] m_rd;

   reg_bank_write_arbiter #(.n(N), .R(R), .AW(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
      .gnt(gnt), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // Advance the model by one edge using the inputs currently applied, then clock the DUT.
   task automatic step();
      int w;
      logic [R-1:0] ereq;
      w    = -1;
      ereq = req & ~m_gnt;
      if (reset) begin
         for (int i = 0; i < D; i++) m_bank[i] = '0;
         m_ptr = 0;
         m_gnt = '0;
         m_rd  = '0;
      end else begin
`ifdef REG_ARB_PRIO0_EN
         if (ereq[0]) w = 0;
`endif
         for (int k = 0; k < R && w < 0; k++)
            if (ereq[PW'((m_ptr + k) % R)]) w = (m_ptr + k) % R;
         m_rd  = m_bank[rd_addr];
         m_gnt = '0;
         if (w >= 0) begin
            m_bank[wr_addr[w*AW +: AW]] = wr_data[w*N +: N];
            m_gnt = 4'b0001 << w;
`ifdef REG_ARB_PRIO0_EN
            if (w != 0) m_ptr = (w + 1) % R;
`else
            m_ptr = (w + 1) % R;
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
      req = req | (4'b0001 << i);
      wr_addr[i*AW +: AW] = a;
      wr_data[i*N +: N]   = d;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=%b", gnt, 4'b0000); end
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt1 got=%b exp=%b", gnt, 4'b0000); end
      n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd got=%h exp=%h", rd_data, 8'h00); end
      reset = 1'b0;
      for (int a = 0; a < D; a++) begin
         rd_addr = AW'(a);
         step();
         n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_read a=%0d got=%h exp=%h", a, rd_data, 8'h00); end
         n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_read_gnt a=%0d got=%b exp=%b", a, gnt, 4'b0000); end
      end
   endtask

   task automatic test_single_write();
      set_req(2, 2'd1, 8'hA5);
      step();
      n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
      req = '0;
      rd_addr = 2'd1;
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_low got=%b exp=%b", gnt, 4'b0000); end
      n_cmp++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_read got=%h exp=%h", rd_data, 8'hA5); end
   endtask

   task automatic test_contention();
      logic [R-1:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pulse_reset();
      for (int i = 0; i < R; i++) set_req(i, AW'(i), N'(8'h10 + i));
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL contention_model c=%0d got=%b exp=%b", c, gnt, m_gnt); end
`ifndef REG_ARB_PRIO0_EN
         n_cmp++; if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL contention_seq c=%0d got=%b exp=%b", c, gnt, exp_seq[c]); end
`endif
      end
      req = '0;
      for (int i = 0; i < R; i++) begin
         rd_addr = AW'(i);
         step();
         n_cmp++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL contention_model_rd i=%0d got=%h exp=%h", i, rd_data, m_rd); end
`ifndef REG_ARB_PRIO0_EN
         n_cmp++; if (rd_data !== N'(8'h10 + i)) begin n_fail++; $display("FAIL contention_read i=%0d got=%h exp=%h", i, rd_data, N'(8'h10 + i)); end
`endif
      end
   endtask

   task automatic test_same_addr();
      pulse_reset();
      set_req(1, 2'd0, 8'h11);
      set_req(3, 2'd0, 8'h33);
      step();
      n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL same_addr_first got=%b exp=%b", gnt, 4'b0010); end
      req[1] = 1'b0;
      step();
      n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL same_addr_second got=%b exp=%b", gnt, 4'b1000); end
      req[3] = 1'b0;
      rd_addr = 2'd0;
      step();
      n_cmp++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL same_addr_final got=%h exp=%h", rd_data, 8'h33); end
   endtask

   task automatic test_read_during_write();
      rd_addr = 2'd2;
      set_req(0, 2'd2, 8'h5A);
      step();
      n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rdw_old got=%h exp=%h", rd_data, 8'h00); end
      n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rdw_gnt got=%b exp=%b", gnt, 4'b0001); end
      req = '0;
      step();
      n_cmp++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL rdw_new got=%h exp=%h", rd_data, 8'h5A); end
   endtask

   task automatic test_reset_mid();
      set_req(1, 2'd3, 8'h21);
      set_req(2, 2'd3, 8'h22);
      set_req(3, 2'd3, 8'h23);
      rd_addr = 2'd2;
      reset = 1'b1;
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=%b", gnt, 4'b0000); end
      reset = 1'b0;
      step();
      n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first got=%b exp=%b", gnt, 4'b0010); end
      n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_cleared got=%h exp=%h", rd_data, 8'h00); end
      req = '0;
      rd_addr = 2'd3;
      step();
      n_cmp++; if (rd_data !== 8'h21) begin n_fail++; $display("FAIL rstmid_write got=%h exp=%h", rd_data, 8'h21); end
   endtask

   task automatic test_back_to_back();
      logic [R-1:0] exp_seq [4];
      exp_seq = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      pulse_reset();
      set_req(3, 2'd1, 8'h77);
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++; if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL b2b c=%0d got=%b exp=%b", c, gnt, exp_seq[c]); end
      end
      req = '0;
   endtask

   task automatic test_prio0();
      logic [R-1:0] exp_seq [4];
      exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      pulse_reset();
      set_req(0, 2'd0, 8'h01);
      set_req(2, 2'd2, 8'h02);
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++; if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL prio0 c=%0d got=%b exp=%b", c, gnt, exp_seq[c]); end
      end
      req = '0;
   endtask

   task automatic test_random();
      pulse_reset();
      for (int c = 0; c < 400; c++) begin
         rd_addr = AW'($urandom_range(0, D - 1));
         reset   = ($urandom_range(0, 63) == 0);
         step();
         n_cmp++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL random_gnt c=%0d got=%b exp=%b", c, gnt, m_gnt); end
         n_cmp++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL random_rd c=%0d got=%h exp=%h", c, rd_data, m_rd); end
         for (int i = 0; i < R; i++) begin
            if (req[PW'(i)] && m_gnt[PW'(i)]) begin
               req[PW'(i)] = ($urandom_range(0, 1) == 1);
               wr_addr[i*AW +: AW] = AW'($urandom_range(0, D - 1));
               wr_data[i*N +: N]   = N'($urandom);
            end else if (!req[PW'(i)] && $urandom_range(0, 2) == 0) begin
               set_req(i, AW'($urandom_range(0, D - 1)), N'($urandom));
            end
         end
      end
      reset = 1'b0;
      req   = '0;
   endtask

   initial begin
      reset   = 1'b1;
      req     = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      test_reset();
      test_single_write();
      test_contention();
      test_same_addr();
      test_read_during_write();
      test_reset_mid();
      test_back_to_back();
      test_prio0();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
